// File: rtl/buzzer_pkg.sv
// Shared zone encodings, FSM state type and the distance-to-zone map for the
// buzzer sequencer.
package buzzer_pkg;

    localparam logic [2:0] Z_SILENT = 3'd0;
    localparam logic [2:0] Z5       = 3'd1;
    localparam logic [2:0] Z4       = 3'd2;
    localparam logic [2:0] Z3       = 3'd3;
    localparam logic [2:0] Z2       = 3'd4;
    localparam logic [2:0] Z_TONE   = 3'd5;

    typedef enum logic [1:0] {
        ST_SILENT = 2'd0,
        ST_ON     = 2'd1,
        ST_OFF    = 2'd2,
        ST_TONE   = 2'd3
    } state_t;

    function automatic logic [2:0] zone_of(input logic [7:0] d);
        logic [2:0] z;
        if (d <= 8'd1)       z = Z_TONE;
        else if (d == 8'd2)  z = Z2;
        else if (d == 8'd3)  z = Z3;
        else if (d == 8'd4)  z = Z4;
        else if (d == 8'd5)  z = Z5;
        else                 z = Z_SILENT;
        return z;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a registered one-clock tick every DIV clocks.
module tick_prescaler #(
    parameter int DIV = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;
    logic          wrap;

    assign wrap  = (cnt_q == CW'(DIV - 1));
    assign cnt_d = wrap ? '0 : cnt_q + 1'b1;
    assign tick  = tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap;
        end
    end

endmodule

// File: rtl/buzzer_sequencer.sv
// Debounces distance samples into a proximity zone and plays the matching
// beep pattern on the buzzer output.
module buzzer_sequencer
    import buzzer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1_000,
    parameter int CONFIRM = 3,
    parameter int PER_Z5  = 800,
    parameter int PER_Z4  = 400,
    parameter int PER_Z3  = 200,
    parameter int PER_Z2  = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] distance,
    input  logic       dist_valid,
    input  logic       mute,
    output logic       alarm,
    output logic [2:0] zone,
    output logic       tick
);

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    tick_prescaler #(.DIV(CLK_HZ / TICK_HZ)) u_presc (
        .clk   (clk),
        .rst_n (rst_int_n),
        .tick  (tick)
    );

    logic [2:0]  zone_map;
    logic [2:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  zone_q, zone_d;
    logic        commit;
    state_t      state_q, state_d;
    logic [15:0] ph_q, ph_d;
    logic [15:0] half;
    logic        alarm_q, alarm_d;

    assign zone_map = zone_of(distance);

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (dist_valid) begin
            if (zone_map == cand_q) begin
                cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
            end else begin
                cand_d = zone_map;
                cnt_d  = 4'd1;
            end
        end
    end

    // Commit on the confirming strobe itself so the zone lands one clock later.
    assign commit = dist_valid && (cnt_d >= 4'(CONFIRM)) && (cand_d != zone_q);
    assign zone_d = commit ? cand_d : zone_q;

    always_comb begin
        case (zone_q)
            Z5:      half = 16'(PER_Z5 / 2);
            Z4:      half = 16'(PER_Z4 / 2);
            Z3:      half = 16'(PER_Z3 / 2);
            Z2:      half = 16'(PER_Z2 / 2);
            default: half = 16'd1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        if (commit) begin
            // A same-cycle tick is dropped: the new pattern starts at ph=0.
            ph_d = 16'd0;
            if (cand_d == Z_SILENT)    state_d = ST_SILENT;
            else if (cand_d == Z_TONE) state_d = ST_TONE;
            else                       state_d = ST_ON;
        end else if (tick && (state_q == ST_ON || state_q == ST_OFF)) begin
            if (ph_q == half - 16'd1) begin
                state_d = (state_q == ST_ON) ? ST_OFF : ST_ON;
                ph_d    = 16'd0;
            end else begin
                ph_d = ph_q + 16'd1;
            end
        end
    end

    assign alarm_d = ((state_q == ST_ON) || (state_q == ST_TONE)) && !mute;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cand_q  <= Z_SILENT;
            cnt_q   <= 4'd0;
            zone_q  <= Z_SILENT;
            state_q <= ST_SILENT;
            ph_q    <= 16'd0;
            alarm_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            zone_q  <= zone_d;
            state_q <= state_d;
            ph_q    <= ph_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
    assign zone  = zone_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed bench for buzzer_sequencer at a 10-clock tick and short beep periods.
module tb_buzzer_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] distance;
    logic       dist_valid;
    logic       mute;
    logic       alarm;
    logic [2:0] zone;
    logic       tick;

    int n_tests = 0;
    int n_fail  = 0;

    buzzer_sequencer #(
        .CLK_HZ(100), .TICK_HZ(10), .CONFIRM(3),
        .PER_Z5(8), .PER_Z4(6), .PER_Z3(4), .PER_Z2(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .distance   (distance),
        .dist_valid (dist_valid),
        .mute       (mute),
        .alarm      (alarm),
        .zone       (zone),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; returns at the sample point just after the capturing edge.
    task automatic strobe(input logic [7:0] d);
        distance   = d;
        dist_valid = 1'b1;
        step();
        dist_valid = 1'b0;
    endtask

    task automatic wait_for(input logic v);
        int k;
        k = 0;
        while (alarm !== v && k < 500) begin
            step();
            k++;
        end
        n_tests++;
        if (alarm !== v) begin
            n_fail++;
            $display("FAIL wait_alarm: alarm=%b, required %b within 500 clk", alarm, v);
        end
    endtask

    task automatic run_len(input logic v, output int n);
        n = 0;
        while (alarm === v && n < 500) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; distance = 8'd255; dist_valid = 1'b0; mute = 1'b0;
        #12;
        n_tests++;
        if ({alarm, zone, tick} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state: alarm/zone/tick=%b/%0d/%b, required 0/0/0", alarm, zone, tick);
        end
        rst_n = 1'b1;
        repeat (3) step();
        n_tests++;
        if (zone !== 3'd0 || alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: zone=%0d alarm=%b, required 0/0", zone, alarm);
        end
    endtask

    task automatic test_tick();
        int n, k;
        k = 0;
        while (tick !== 1'b1 && k < 30) begin step(); k++; end
        step();
        n_tests++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_width: tick=%b one clk after pulse, required 0", tick);
        end
        n = 1;
        while (tick !== 1'b1 && n < 30) begin step(); n++; end
        n_tests++;
        if (n != 10) begin
            n_fail++;
            $display("FAIL tick_period: %0d clk, required 10", n);
        end
    endtask

    task automatic test_z5();
        int n;
        strobe(8'd5);
        strobe(8'd5);
        n_tests++;
        if (zone !== 3'd0) begin
            n_fail++;
            $display("FAIL z5_early: zone=%0d after 2 strobes, required 0", zone);
        end
        strobe(8'd5);
        n_tests++;
        if (zone !== 3'd1) begin
            n_fail++;
            $display("FAIL z5_commit: zone=%0d, required 1", zone);
        end
        step();
        n_tests++;
        if (alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL z5_on: alarm=%b one clk after commit, required 1", alarm);
        end
        run_len(1'b1, n);
        run_len(1'b0, n);
        n_tests++;
        if (n != 40) begin
            n_fail++;
            $display("FAIL z5_off_len: %0d clk, required 40", n);
        end
        run_len(1'b1, n);
        n_tests++;
        if (n != 40) begin
            n_fail++;
            $display("FAIL z5_on_len: %0d clk, required 40", n);
        end
    endtask

    task automatic test_debounce_z4();
        int n;
        logic [7:0] seq [5] = '{8'd4, 8'd4, 8'd9, 8'd4, 8'd4};
        for (int i = 0; i < 5; i++) strobe(seq[i]);
        n_tests++;
        if (zone !== 3'd1) begin
            n_fail++;
            $display("FAIL z4_broken_run: zone=%0d, required 1", zone);
        end
        strobe(8'd4);
        n_tests++;
        if (zone !== 3'd2) begin
            n_fail++;
            $display("FAIL z4_commit: zone=%0d, required 2", zone);
        end
        step();
        n_tests++;
        if (alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL z4_restart_on: alarm=%b, required 1", alarm);
        end
        run_len(1'b1, n);
        run_len(1'b0, n);
        n_tests++;
        if (n != 30) begin
            n_fail++;
            $display("FAIL z4_off_len: %0d clk, required 30", n);
        end
        run_len(1'b1, n);
        n_tests++;
        if (n != 30) begin
            n_fail++;
            $display("FAIL z4_on_len: %0d clk, required 30", n);
        end
    endtask

    task automatic test_tone_silent();
        int lows;
        repeat (3) strobe(8'd0);
        n_tests++;
        if (zone !== 3'd5) begin
            n_fail++;
            $display("FAIL tone_commit: zone=%0d, required 5", zone);
        end
        lows = 0;
        repeat (50) begin
            step();
            if (alarm !== 1'b1) lows++;
        end
        n_tests++;
        if (lows != 0) begin
            n_fail++;
            $display("FAIL tone_steady: %0d low clk, required 0", lows);
        end
        strobe(8'd200);
        strobe(8'd200);
        n_tests++;
        if (zone !== 3'd5) begin
            n_fail++;
            $display("FAIL silent_early: zone=%0d, required 5", zone);
        end
        strobe(8'd200);
        n_tests++;
        if (zone !== 3'd0 || alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL silent_commit: zone=%0d alarm=%b, required 0/1", zone, alarm);
        end
        step();
        n_tests++;
        if (alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL silent_alarm: alarm=%b, required 0", alarm);
        end
    endtask

    task automatic test_mute();
        int err_m, err_r;
        logic exp_a;
        repeat (3) strobe(8'd2);
        n_tests++;
        if (zone !== 3'd4) begin
            n_fail++;
            $display("FAIL z2_commit: zone=%0d, required 4", zone);
        end
        wait_for(1'b1);
        wait_for(1'b0);
        wait_for(1'b1);
        err_m = 0; err_r = 0;
        for (int t = 1; t <= 48; t++) begin
            step();
            exp_a = ((t / 10) % 2) == 0;
            if (t >= 4 && t <= 28) begin
                if (alarm !== 1'b0) err_m++;
            end else if (alarm !== exp_a) begin
                err_r++;
            end
            if (t == 3)  mute = 1'b1;
            if (t == 28) mute = 1'b0;
        end
        n_tests++;
        if (err_m != 0) begin
            n_fail++;
            $display("FAIL mute_hold: %0d clk with alarm high, required 0", err_m);
        end
        n_tests++;
        if (err_r != 0) begin
            n_fail++;
            $display("FAIL mute_phase: %0d clk off-pattern, required 0", err_r);
        end
    endtask

    task automatic test_commit_on_tick();
        int k, n;
        strobe(8'd3);
        strobe(8'd3);
        k = 0;
        while (tick !== 1'b1 && k < 30) begin step(); k++; end
        strobe(8'd3);
        n_tests++;
        if (zone !== 3'd3) begin
            n_fail++;
            $display("FAIL tick_commit: zone=%0d, required 3", zone);
        end
        step();
        run_len(1'b1, n);
        n_tests++;
        if (n != 20) begin
            n_fail++;
            $display("FAIL tick_commit_on_len: %0d clk, required 20", n);
        end
    endtask

    task automatic test_async_reset();
        wait_for(1'b1);
        step();
        step();
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (alarm !== 1'b0 || zone !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: alarm=%b zone=%0d, required 0/0", alarm, zone);
        end
        #2 rst_n = 1'b1;
        repeat (4) step();
        strobe(8'd3);
        strobe(8'd3);
        n_tests++;
        if (zone !== 3'd0 || alarm !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_early: zone=%0d alarm=%b, required 0/0", zone, alarm);
        end
        strobe(8'd3);
        n_tests++;
        if (zone !== 3'd3) begin
            n_fail++;
            $display("FAIL rearm_commit: zone=%0d, required 3", zone);
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_z5();
        test_debounce_z4();
        test_tone_silent();
        test_mute();
        test_commit_on_tick();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
